// File: rtl/pll_drp_ctrl.sv
// rtl/pll_drp_ctrl.sv - PLLE2 CLKOUT0 divider reconfiguration over DRP with bounded lock wait.
// Optional PLL_DRP_READBACK_EN re-reads each written register and flags a mismatch.
module pll_drp_ctrl #(
    parameter int unsigned LockTimeout = 65535,
    parameter int unsigned DrdyTimeout = 255,
    parameter int unsigned RstHold     = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [6:0]  div_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [6:0]  daddr_o,
    output logic [15:0] di_o,
    output logic        den_o,
    output logic        dwe_o,
    input  logic [15:0] do_i,
    input  logic        drdy_i,
    output logic        pll_rst_o,
    input  logic        locked_i,
    output logic        rst_sys_n_o
);

    localparam int unsigned TMax = (LockTimeout > DrdyTimeout)
        ? ((LockTimeout > RstHold) ? LockTimeout : RstHold)
        : ((DrdyTimeout > RstHold) ? DrdyTimeout : RstHold);
    localparam int TW = $clog2(TMax + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ASSERT_RST, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
`ifdef PLL_DRP_READBACK_EN
        S_VERIFY_RD, S_VERIFY_WAIT,
`endif
        S_HOLD, S_WAIT_LOCK, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     div_q, div_d;
    logic           reg_q, reg_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    di_q, di_d;
    logic [6:0]     daddr_q, daddr_d;
    logic           den_q, den_d, dwe_q, dwe_d;
    logic           pll_rst_q, pll_rst_d, busy_q, busy_d;
    logic           done_q, done_d, err_q, err_d;
    logic           lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;

    logic           no_count, edge_bit, advance, abort, drdy_late;
    logic [5:0]     high_t, low_t;
    logic [6:0]     low_full;
    logic [15:0]    keep_mask, new_bits;

    // Divide-by-1 bypasses the counter: fixed 1/1 times, edge forced low.
    always_comb begin
        no_count  = (div_q == 7'd1);
        low_full  = div_q - {1'b0, div_q[6:1]};
        high_t    = no_count ? 6'd1 : div_q[6:1];
        low_t     = no_count ? 6'd1 : low_full[5:0];
        edge_bit  = div_q[0] & ~no_count;
        keep_mask = reg_q ? 16'hFF00 : 16'hF000;
        new_bits  = reg_q ? {8'h00, edge_bit, no_count, 6'd0} : {4'h0, high_t, low_t};
        drdy_late = (timer_q == TW'(DrdyTimeout - 1));
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        reg_d     = reg_q;
        timer_d   = timer_q;
        di_d      = di_q;
        daddr_d   = daddr_q;
        den_d     = 1'b0;
        dwe_d     = 1'b0;
        pll_rst_d = pll_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        lock_s1_d = locked_i;
        lock_s2_d = lock_s1_q;
        advance   = 1'b0;
        abort     = 1'b0;

        case (state_q)
            S_IDLE: if (req_i) begin
                if (div_i == 7'd0) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    div_d     = div_i;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    pll_rst_d = 1'b1;
                    reg_d     = 1'b0;
                    state_d   = S_ASSERT_RST;
                end
            end
            S_ASSERT_RST: begin
                state_d = S_RD;
                den_d   = 1'b1;
                daddr_d = 7'h08;
            end
            S_RD: begin
                state_d = S_RD_WAIT;
                timer_d = '0;
            end
            S_RD_WAIT: begin
                if (drdy_i) begin
                    di_d    = (do_i & keep_mask) | new_bits;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = S_WR;
                end else if (drdy_late) abort = 1'b1;
                else timer_d = timer_q + 1'b1;
            end
            S_WR: begin
                state_d = S_WR_WAIT;
                timer_d = '0;
            end
            S_WR_WAIT: begin
                if (drdy_i) begin
`ifdef PLL_DRP_READBACK_EN
                    den_d   = 1'b1;
                    state_d = S_VERIFY_RD;
`else
                    advance = 1'b1;
`endif
                end else if (drdy_late) abort = 1'b1;
                else timer_d = timer_q + 1'b1;
            end
`ifdef PLL_DRP_READBACK_EN
            S_VERIFY_RD: begin
                state_d = S_VERIFY_WAIT;
                timer_d = '0;
            end
            S_VERIFY_WAIT: begin
                if (drdy_i) begin
                    if (do_i != di_q) abort = 1'b1;
                    else advance = 1'b1;
                end else if (drdy_late) abort = 1'b1;
                else timer_d = timer_q + 1'b1;
            end
`endif
            S_HOLD: begin
                if (timer_q == TW'(RstHold - 1)) begin
                    pll_rst_d = 1'b0;
                    state_d   = S_WAIT_LOCK;
                    timer_d   = '0;
                end else timer_d = timer_q + 1'b1;
            end
            S_WAIT_LOCK: begin
                if (lock_s2_q || timer_q == TW'(LockTimeout - 1)) begin
                    err_d   = err_q | ~lock_s2_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else timer_d = timer_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (!reg_q) begin
                reg_d   = 1'b1;
                den_d   = 1'b1;
                daddr_d = 7'h09;
                state_d = S_RD;
            end else begin
                state_d = S_HOLD;
                timer_d = '0;
            end
        end
        // Aborted sequences still release the PLL and wait for lock before DONE.
        if (abort) begin
            err_d     = 1'b1;
            pll_rst_d = 1'b0;
            state_d   = S_WAIT_LOCK;
            timer_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            reg_q     <= 1'b0;
            timer_q   <= '0;
            di_q      <= '0;
            daddr_q   <= '0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            pll_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            reg_q     <= reg_d;
            timer_q   <= timer_d;
            di_q      <= di_d;
            daddr_q   <= daddr_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            pll_rst_q <= pll_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            lock_s1_q <= lock_s1_d;
            lock_s2_q <= lock_s2_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign daddr_o     = daddr_q;
    assign di_o        = di_q;
    assign den_o       = den_q;
    assign dwe_o       = dwe_q;
    assign pll_rst_o   = pll_rst_q;
    assign rst_sys_n_o = lock_s2_q & ~busy_q & rst_ni;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb/tb_pll_drp_ctrl.sv - scoreboard bench for pll_drp_ctrl with DRP register and PLL lock models.
module tb_pll_drp_ctrl;
    localparam int LT = 40, DT = 10, RH = 5, LOCK_DLY = 4;

    logic        clk = 1'b0, rst_ni = 1'b0, req_i = 1'b0;
    logic [6:0]  div_i = '0;
    logic        busy_o, done_o, err_o, den_o, dwe_o, pll_rst_o, rst_sys_n_o;
    logic [6:0]  daddr_o;
    logic [15:0] di_o;
    logic [15:0] do_i = '0;
    logic        drdy_i = 1'b0, locked_i = 1'b0;

    pll_drp_ctrl #(.LockTimeout(LT), .DrdyTimeout(DT), .RstHold(RH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .div_i(div_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .daddr_o(daddr_o), .di_o(di_o), .den_o(den_o), .dwe_o(dwe_o),
        .do_i(do_i), .drdy_i(drdy_i), .pll_rst_o(pll_rst_o),
        .locked_i(locked_i), .rst_sys_n_o(rst_sys_n_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [6:0] a; logic [15:0] d; } wr_t;
    wr_t exp_q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;

    // DRP register file and PLL lock behaviour
    logic [15:0] mem [0:127];
    logic [15:0] init8 = 16'hF30C, init9 = 16'hA5C3;
    bit load = 0, respond = 1, corrupt = 0, lock_stuck = 0;
    int lk_cnt = 0;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        drdy_i <= 1'b0;
        if (load) begin
            mem[8] <= init8;
            mem[9] <= init9;
        end
        if (den_o && respond) begin
            drdy_i <= 1'b1;
            if (dwe_o) mem[daddr_o] <= di_o;
            else do_i <= mem[daddr_o] ^ (corrupt ? 16'h8000 : 16'h0000);
        end
        if (pll_rst_o || lock_stuck) begin
            lk_cnt   <= 0;
            locked_i <= 1'b0;
        end else if (lk_cnt < LOCK_DLY) lk_cnt <= lk_cnt + 1;
        else locked_i <= 1'b1;
    end

    int den_cnt, last_wr_cyc, busy_rise_cyc, rst_fall_cyc, lock_rise_cyc, done_cyc, req_cyc;
    bit rst_seen, busy_seen, done_seen, done_err, done_busy, done_rst;
    bit busy_prev = 0, rst_prev = 0, lk_prev = 0;
    wr_t e;
    always @(negedge clk) begin
        if (den_o) den_cnt++;
        if (den_o && dwe_o) begin
            last_wr_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL drp_write: got addr %h data %h, required no write", daddr_o, di_o);
            end else begin
                e = exp_q.pop_front();
                if ({daddr_o, di_o} !== {e.a, e.d}) begin
                    n_bad++;
                    $display("FAIL drp_write: got addr %h data %h, required addr %h data %h",
                             daddr_o, di_o, e.a, e.d);
                end
            end
        end
        if (busy_o && !busy_prev) busy_rise_cyc = cyc;
        if (!pll_rst_o && rst_prev) rst_fall_cyc = cyc;
        if (locked_i && !lk_prev) lock_rise_cyc = cyc;
        if (pll_rst_o) rst_seen = 1;
        if (busy_o) busy_seen = 1;
        if (done_o) begin
            done_seen = 1; done_cyc = cyc;
            done_err = err_o; done_busy = busy_o; done_rst = pll_rst_o;
        end
        busy_prev = busy_o; rst_prev = pll_rst_o; lk_prev = locked_i;
    end

    function automatic logic [15:0] exp_reg1(logic [15:0] old, int d);
        int hi = (d == 1) ? 1 : d / 2;
        int lo = (d == 1) ? 1 : d - d / 2;
        return (old & 16'hF000) | 16'(((hi % 64) * 64) + (lo % 64));
    endfunction

    function automatic logic [15:0] exp_reg2(logic [15:0] old, int d);
        int ed = (d % 2 == 1 && d != 1) ? 1 : 0;
        int nc = (d == 1) ? 1 : 0;
        return (old & 16'hFF00) | 16'(ed * 128 + nc * 64);
    endfunction

    task automatic push_rmw(int d);
        logic [15:0] cm = corrupt ? 16'h8000 : 16'h0000;
        exp_q.push_back('{7'h08, exp_reg1(mem[8] ^ cm, d)});
        exp_q.push_back('{7'h09, exp_reg2(mem[9] ^ cm, d)});
    endtask

    task automatic clear_mon();
        den_cnt = 0; rst_seen = 0; busy_seen = 0; done_seen = 0;
    endtask

    task automatic issue(int d);
        @(negedge clk);
        div_i = 7'(d); req_i = 1'b1; req_cyc = cyc;
        @(negedge clk);
        req_i = 1'b0;
    endtask

    task automatic wait_done(int budget, string name);
        for (int i = 0; i < budget && !done_seen; i++) @(negedge clk);
        n_cmp++;
        if (!done_seen) begin
            n_bad++;
            $display("FAIL %s_done: got no done_o within %0d cycles, required done_o pulse", name, budget);
        end
    endtask

    task automatic test_reset();
        load = 1;
        repeat (2) @(negedge clk);
        load = 0;
        n_cmp++;
        if ({busy_o, done_o, err_o, daddr_o, di_o, den_o, dwe_o, pll_rst_o, rst_sys_n_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy%b done%b err%b addr%h di%h den%b dwe%b rst%b sys%b, required all 0",
                     busy_o, done_o, err_o, daddr_o, di_o, den_o, dwe_o, pll_rst_o, rst_sys_n_o);
        end
        rst_ni = 1'b1;
        repeat (LOCK_DLY + 6) @(negedge clk);
        n_cmp++;
        if (rst_sys_n_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_sys: got %b, required 1", rst_sys_n_o);
        end
    endtask

    task automatic test_div24();
        clear_mon();
        push_rmw(24);
        issue(24);
        wait_done(300, "div24");
        n_cmp++;
        if (done_err !== 1'b0 || done_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL div24_flags: got err %b busy %b, required 0 0", done_err, done_busy);
        end
        n_cmp++;
        if (busy_rise_cyc != req_cyc + 1) begin
            n_bad++;
            $display("FAIL div24_busy_rise: got cycle %0d, required %0d", busy_rise_cyc, req_cyc + 1);
        end
        // 1 reset cycle + 2 registers x (read + write) x 2 cycles + hold
        n_cmp++;
        if (rst_fall_cyc - busy_rise_cyc != 9 + RH) begin
            n_bad++;
            $display("FAIL div24_rst_latency: got %0d, required %0d", rst_fall_cyc - busy_rise_cyc, 9 + RH);
        end
        n_cmp++;
        if (rst_fall_cyc - last_wr_cyc != RH + 2) begin
            n_bad++;
            $display("FAIL div24_hold: got %0d, required %0d", rst_fall_cyc - last_wr_cyc, RH + 2);
        end
        n_cmp++;
        if (done_cyc - lock_rise_cyc < 3) begin
            n_bad++;
            $display("FAIL div24_lock_to_done: got %0d, required >= 3", done_cyc - lock_rise_cyc);
        end
        n_cmp++;
        if (den_cnt != 4 || exp_q.size() != 0 || mem[8] !== 16'hF30C || mem[9] !== 16'hA500) begin
            n_bad++;
            $display("FAIL div24_regs: got den %0d left %0d reg1 %h reg2 %h, required 4 0 f30c a500",
                     den_cnt, exp_q.size(), mem[8], mem[9]);
        end
    endtask

    task automatic test_div0();
        clear_mon();
        issue(0);
        wait_done(20, "div0");
        n_cmp++;
        if (done_cyc != req_cyc + 1 || done_err !== 1'b1) begin
            n_bad++;
            $display("FAIL div0_done: got cycle %0d err %b, required cycle %0d err 1", done_cyc, done_err, req_cyc + 1);
        end
        n_cmp++;
        if (den_cnt != 0 || rst_seen || busy_seen) begin
            n_bad++;
            $display("FAIL div0_quiet: got den %0d rst %b busy %b, required 0 0 0", den_cnt, rst_seen, busy_seen);
        end
    endtask

    task automatic test_div1();
        clear_mon();
        push_rmw(1);
        issue(1);
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL div1_err_clear: got %b, required 0", err_o);
        end
        wait_done(300, "div1");
        n_cmp++;
        if (done_err !== 1'b0 || mem[9][7:0] !== 8'h40 || mem[8][11:0] !== 12'h041 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL div1_regs: got err %b reg2lo %h reg1lo %h left %0d, required 0 40 041 0",
                     done_err, mem[9][7:0], mem[8][11:0], exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        push_rmw(7);
        issue(7);
        @(negedge clk);
        div_i = 7'd99; req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        wait_done(300, "div7");
        n_cmp++;
        if (done_err !== 1'b0 || den_cnt != 4 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL div7_single: got err %b den %0d left %0d, required 0 4 0", done_err, den_cnt, exp_q.size());
        end
        n_cmp++;
        if (mem[8][11:0] !== 12'h0C4 || mem[9][7:0] !== 8'h80) begin
            n_bad++;
            $display("FAIL div7_regs: got reg1lo %h reg2lo %h, required 0c4 80", mem[8][11:0], mem[9][7:0]);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || den_cnt != 4) begin
            n_bad++;
            $display("FAIL div7_no_queue: got busy %b den %0d, required 0 4", busy_o, den_cnt);
        end
    endtask

    task automatic test_drdy_timeout();
        respond = 0;
        clear_mon();
        issue(5);
        wait_done(300, "drdy_to");
        respond = 1;
        n_cmp++;
        if (done_err !== 1'b1 || done_rst !== 1'b0 || den_cnt != 1) begin
            n_bad++;
            $display("FAIL drdy_to_flags: got err %b rst %b den %0d, required 1 0 1", done_err, done_rst, den_cnt);
        end
        n_cmp++;
        if (rst_fall_cyc - busy_rise_cyc != DT + 2) begin
            n_bad++;
            $display("FAIL drdy_to_abort: got %0d, required %0d", rst_fall_cyc - busy_rise_cyc, DT + 2);
        end
    endtask

    task automatic test_lock_timeout();
        lock_stuck = 1;
        clear_mon();
        push_rmw(9);
        issue(9);
        wait_done(300, "lock_to");
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_err !== 1'b1 || done_cyc - rst_fall_cyc != LT || rst_sys_n_o !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL lock_to: got err %b wait %0d sys %b left %0d, required 1 %0d 0 0",
                     done_err, done_cyc - rst_fall_cyc, rst_sys_n_o, exp_q.size(), LT);
        end
        lock_stuck = 0;
        repeat (LOCK_DLY + 6) @(negedge clk);
    endtask

    task automatic test_reset_in_hold();
        int i;
        clear_mon();
        push_rmw(10);
        issue(10);
        for (i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pll_rst_o !== 1'b1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL hold_reached: got rst %b left %0d, required 1 0", pll_rst_o, exp_q.size());
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, daddr_o, di_o, den_o, dwe_o, pll_rst_o, rst_sys_n_o} !== '0) begin
            n_bad++;
            $display("FAIL hold_reset_outputs: got busy%b rst%b sys%b den%b addr%h di%h, required all 0",
                     busy_o, pll_rst_o, rst_sys_n_o, den_o, daddr_o, di_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (LOCK_DLY + 6) @(negedge clk);
        clear_mon();
        push_rmw(24);
        issue(24);
        wait_done(300, "after_reset");
        n_cmp++;
        if (done_err !== 1'b0 || exp_q.size() != 0 || mem[8][11:0] !== 12'h30C) begin
            n_bad++;
            $display("FAIL after_reset: got err %b left %0d reg1lo %h, required 0 0 30c",
                     done_err, exp_q.size(), mem[8][11:0]);
        end
    endtask

`ifdef PLL_DRP_READBACK_EN
    task automatic test_readback();
        corrupt = 1;
        clear_mon();
        exp_q.push_back('{7'h08, exp_reg1(mem[8] ^ 16'h8000, 20)});
        issue(20);
        wait_done(300, "readback");
        corrupt = 0;
        n_cmp++;
        if (done_err !== 1'b1 || done_rst !== 1'b0 || den_cnt != 3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL readback: got err %b rst %b den %0d left %0d, required 1 0 3 0",
                     done_err, done_rst, den_cnt, exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div24();
        test_div0();
        test_div1();
        test_back_to_back();
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_in_hold();
`ifdef PLL_DRP_READBACK_EN
        test_readback();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
